prio_enc_pipe: RTL

//  Parametrised, pipelined LSB-first priority encoder: returns the index of the lowest set bit of

---
 rtl/prio_enc_pkg.sv | 32 +++
 rtl/prio_enc_pipe_if.sv | 26 ++
 rtl/prio_enc_node4.sv | 62 ++++++
 rtl/prio_enc_pipe.sv | 108 ++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants, helpers and node record for the pipelined priority encoder.
package prio_enc_pkg;

   localparam int unsigned LeafW   = 4;
   localparam int unsigned MaxIdxW = 8;

   // Ceiling log4, i.e. number of radix-4 tree levels needed to cover n leaves.
   function automatic int unsigned clog4(int unsigned n);
      int unsigned lvl = 0;
      int unsigned cap = 1;
      for (int i = 0; i < 16; i++) begin
         if (cap < n) begin
            cap = cap * 4;
            lvl++;
         end
      end
      return lvl;
   endfunction

   // Node count at a tree level; a non power-of-4 top level collapses to one radix-2 node.
   function automatic int unsigned lvl_nodes(int unsigned width, int unsigned lvl);
      int unsigned n;
      n = width >> (2 * (lvl + 1));
      return (n == 0) ? 1 : n;
   endfunction

   typedef struct packed {
      logic               any;
      logic [MaxIdxW-1:0] idx;
   } node_t;

endpackage

// File: rtl/prio_enc_pipe_if.sv
// Request/result bundle between a requester and the pipelined priority encoder.
interface prio_enc_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned IDX_W = $clog2(WIDTH);

   logic             in_valid;
   logic [WIDTH-1:0] din;
   logic             ce;
   logic             out_valid;
   logic             out_found;
   logic [IDX_W-1:0] out_idx;
   logic [WIDTH-1:0] out_onehot;
   logic [WIDTH-1:0] out_resid;

   modport master (
      output in_valid, din, ce,
      input  out_valid, out_found, out_idx, out_onehot, out_resid
   );

   modport slave (
      input  in_valid, din, ce,
      output out_valid, out_found, out_idx, out_onehot, out_resid
   );

endinterface

// File: rtl/prio_enc_node4.sv
// Registered 4-input lowest-first combine: picks the lowest child with any set and
// prefixes its index with the child number.
module prio_enc_node4 #(
   parameter  int unsigned ChildIdxW  = 0,
   parameter  int unsigned SimEmulate = 0,
   localparam int unsigned CIW        = (ChildIdxW == 0) ? 1 : ChildIdxW,
   localparam int unsigned OutW       = ChildIdxW + 2
) (
   input  logic             clk,
   input  logic             ce,
   input  logic [3:0]       child_any,
   input  logic [4*CIW-1:0] child_idx,
   output logic             any_q,
   output logic [OutW-1:0]  idx_q
);

   logic [1:0]      sel;
   logic [CIW-1:0]  chosen;
   logic [OutW-1:0] idx_d;

   // Both variants agree whenever any child is set; sel is a don't-care otherwise.
   if (SimEmulate != 0) begin : g_beh
      always_comb begin
         sel = 2'd0;
         for (int i = 3; i >= 0; i--) begin
            if (child_any[i]) sel = 2'(i);
         end
      end
   end else begin : g_opt
      always_comb begin
         casez (child_any)
            4'b???1: sel = 2'd0;
            4'b??10: sel = 2'd1;
            4'b?100: sel = 2'd2;
            default: sel = 2'd3;
         endcase
      end
   end

   always_comb begin
      chosen = child_idx[CIW-1:0];
      for (int i = 1; i < 4; i++) begin
         if (sel == 2'(i)) chosen = child_idx[i*CIW +: CIW];
      end
   end

   if (ChildIdxW == 0) begin : g_leaf
      logic unused_chosen;
      assign unused_chosen = ^chosen;
      assign idx_d = sel;
   end else begin : g_inner
      assign idx_d = {sel, chosen};
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         any_q <= |child_any;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/prio_enc_pipe.sv
// Pipelined LSB-first priority encoder: radix-4 tree, one register per level, with
// found flag, one-hot grant and residual vector for iterative scans.
module prio_enc_pipe
   import prio_enc_pkg::*;
#(
   parameter  int unsigned WIDTH       = 16,
   parameter  int unsigned RESID_EN    = 1,
   parameter  int unsigned SIM_EMULATE = 0,
   localparam int unsigned IDX_W       = $clog2(WIDTH),
   localparam int unsigned LAT         = (clog4(WIDTH) > 1) ? clog4(WIDTH) : 1
) (
   input logic            clk,
   input logic            rst,
   prio_enc_pipe_if.slave bus
);

   localparam int unsigned NLeaf = WIDTH / LeafW;

   node_t [LAT-1:0][NLeaf-1:0] tree;
   logic  [LAT-1:0]            vld_q;
   logic  [WIDTH-1:0]          din_last;
   logic  [IDX_W-1:0]          top_idx;
   logic  [WIDTH-1:0]          onehot;
   logic                       found;
   logic                       unused_tree;

   for (genvar k = 0; k < LAT; k++) begin : g_lvl
      localparam int unsigned NN  = lvl_nodes(WIDTH, k);
      localparam int unsigned CW  = 2 * k;
      localparam int unsigned CIW = (CW == 0) ? 1 : CW;

      for (genvar n = 0; n < NLeaf; n++) begin : g_node
         if (n < NN) begin : g_used
            logic [3:0]       c_any;
            logic [4*CIW-1:0] c_idx;
            logic             any_q;
            logic [CW+1:0]    idx_q;

            if (k == 0) begin : g_leaf
               assign c_any = bus.din[4*n +: 4];
               assign c_idx = '0;
            end else begin : g_inner
               for (genvar c = 0; c < 4; c++) begin : g_ch
                  // Radix-2 top level: children 2 and 3 do not exist.
                  if (4 * n + c < lvl_nodes(WIDTH, k - 1)) begin : g_live
                     assign c_any[c]              = tree[k-1][4*n+c].any;
                     assign c_idx[c*CIW +: CIW]   = tree[k-1][4*n+c].idx[CIW-1:0];
                  end else begin : g_pad
                     assign c_any[c]              = 1'b0;
                     assign c_idx[c*CIW +: CIW]   = '0;
                  end
               end
            end

            prio_enc_node4 #(
               .ChildIdxW  (CW),
               .SimEmulate (SIM_EMULATE)
            ) u_node (
               .clk       (clk),
               .ce        (bus.ce),
               .child_any (c_any),
               .child_idx (c_idx),
               .any_q     (any_q),
               .idx_q     (idx_q)
            );

            assign tree[k][n] = {any_q, MaxIdxW'(idx_q)};
         end else begin : g_empty
            assign tree[k][n] = '0;
         end
      end
   end

   assign unused_tree = ^tree;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else if (bus.ce) begin
         vld_q[0] <= bus.in_valid;
         for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   if (RESID_EN != 0) begin : g_resid
      logic [WIDTH-1:0] din_q [LAT];
      always_ff @(posedge clk) begin
         if (bus.ce) begin
            din_q[0] <= bus.din;
            for (int i = 1; i < LAT; i++) din_q[i] <= din_q[i-1];
         end
      end
      assign din_last = din_q[LAT-1];
   end else begin : g_no_resid
      assign din_last = '0;
   end

   assign top_idx = tree[LAT-1][0].idx[IDX_W-1:0];
   assign found   = vld_q[LAT-1] & tree[LAT-1][0].any;
   assign onehot  = found ? (WIDTH'(1) << top_idx) : '0;

   assign bus.out_valid  = vld_q[LAT-1];
   assign bus.out_found  = found;
   assign bus.out_idx    = found ? top_idx : '0;
   assign bus.out_onehot = onehot;
   assign bus.out_resid  = vld_q[LAT-1] ? (din_last & ~onehot) : '0;

endmodule
